// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding,
// default frame-start byte and instruction word width.
package boot_loader_pkg;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam int         IWORD_W       = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } state_t;

endpackage

// File: rtl/boot_loader.sv
// Byte-stream program loader: frames MAGIC/len/data/checksum, packs bytes
// into 16-bit words for instruction memory and holds the core in reset.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | hunting for MAGIC, other bytes dropped
// LEN_HI  | expecting word-count high byte
// LEN_LO  | expecting word-count low byte, range check
// DATA_HI | expecting high byte of next instruction word
// DATA_LO | expecting low byte; write issued on the following cycle
// CHECK   | expecting XOR checksum of all data bytes
// DONE    | image accepted, core released, input stalled
// ERROR   | framing/checksum failure, waits for MAGIC or reload
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [7:0]  MAGIC     = MAGIC_DEFAULT,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic               reload,
  output logic               imem_we,
  output logic [15:0]        imem_addr,
  output logic [IWORD_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               load_ok,
  output logic               load_err,
  output logic [15:0]        words_loaded
);

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          chk_q, chk_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [15:0]         addr_q, addr_d;
  logic [IWORD_W-1:0]  wdata_q, wdata_d;
  logic [15:0]         words_q, words_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                hold_q, hold_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;

  logic                hs;
  logic [15:0]         len_full;

  assign hs       = in_valid && ready_q;
  assign len_full = {len_q[15:8], in_data};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    chk_d   = chk_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    words_d = words_q;
    case (state_q)
      IDLE: if (hs && in_data == MAGIC) state_d = LEN_HI;
      LEN_HI: if (hs) begin
        len_d[15:8] = in_data;
        state_d     = LEN_LO;
      end
      LEN_LO: if (hs) begin
        len_d = len_full;
        if (len_full == 16'd0 || 32'(len_full) > MAX_WORDS) begin
          state_d = ERROR;
        end else begin
          chk_d   = 8'h00;
          cnt_d   = 16'd0;
          words_d = 16'd0;
          state_d = DATA_HI;
        end
      end
      DATA_HI: if (hs) begin
        hi_d    = in_data;
        chk_d   = chk_q ^ in_data;
        state_d = DATA_LO;
      end
      // The write register absorbs the word so input never stalls here.
      DATA_LO: if (hs) begin
        chk_d   = chk_q ^ in_data;
        we_d    = 1'b1;
        addr_d  = BASE_ADDR + (cnt_q << 1);
        wdata_d = {hi_q, in_data};
        cnt_d   = cnt_q + 16'd1;
        words_d = words_q + 16'd1;
        state_d = (cnt_q + 16'd1 == len_q) ? CHECK : DATA_HI;
      end
      CHECK: if (hs) state_d = (in_data == chk_q) ? DONE : ERROR;
      DONE: if (reload) begin
        state_d = IDLE;
        words_d = 16'd0;
      end
      ERROR: begin
        if (hs && in_data == MAGIC) state_d = LEN_HI;
        else if (reload)            state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d != DONE);
    busy_d  = (state_d inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK});
    hold_d  = (state_d != DONE);
    ok_d    = (state_d == DONE);
    err_d   = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      len_q   <= 16'd0;
      hi_q    <= 8'h00;
      chk_q   <= 8'h00;
      cnt_q   <= 16'd0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      words_q <= 16'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      hold_q  <= 1'b1;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      words_q <= words_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign in_ready     = ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign load_ok      = ok_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (base 0000 and 0100) share one byte
// stream; a frame-level model is compared against both on every cycle.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        reload = 1'b0;

  logic        ready_a, we_a, hold_a, busy_a, ok_a, err_a;
  logic [15:0] addr_a, wdata_a, words_a;
  logic        ready_b, we_b, hold_b, busy_b, ok_b, err_b;
  logic [15:0] addr_b, wdata_b, words_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  boot_loader dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ready_a), .reload(reload), .imem_we(we_a), .imem_addr(addr_a),
    .imem_wdata(wdata_a), .cpu_hold(hold_a), .busy(busy_a), .load_ok(ok_a),
    .load_err(err_a), .words_loaded(words_a)
  );

  boot_loader #(.BASE_ADDR(16'h0100)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ready_b), .reload(reload), .imem_we(we_b), .imem_addr(addr_b),
    .imem_wdata(wdata_b), .cpu_hold(hold_b), .busy(busy_b), .load_ok(ok_b),
    .load_err(err_b), .words_loaded(words_b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: modes and byte position within the frame.
  localparam int M_HUNT = 0, M_FRAME = 1, M_OK = 2, M_ERR = 3;
  int          m_mode = M_HUNT;
  int          m_pos, m_len, m_words, m_idx;
  logic [7:0]  m_lenhi, m_x, m_hi;
  logic        m_we, m_ready = 1'b1;
  logic [15:0] m_wdata;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    bit hs;
    hs   = in_valid && m_ready;
    m_we = 1'b0;
    if (!reset) begin
      m_mode = M_HUNT; m_words = 0; m_idx = 0; m_wdata = 16'h0000;
      model_on = 1'b1;
    end else begin
      case (m_mode)
        M_HUNT: if (hs && in_data == 8'hA5) begin m_mode = M_FRAME; m_pos = 0; end
        M_FRAME: if (hs) begin
          if (m_pos == 0) m_lenhi = in_data;
          else if (m_pos == 1) begin
            m_len = {m_lenhi, in_data};
            if (m_len == 0 || m_len > 256) m_mode = M_ERR;
            else begin m_x = 8'h00; m_words = 0; end
          end else if (m_pos < 2 + 2 * m_len) begin
            m_x = m_x ^ in_data;
            if (m_pos % 2 == 0) m_hi = in_data;
            else begin
              m_we = 1'b1; m_idx = m_words; m_wdata = {m_hi, in_data}; m_words++;
            end
          end else m_mode = (in_data == m_x) ? M_OK : M_ERR;
          m_pos++;
        end
        M_OK: if (reload) begin m_mode = M_HUNT; m_words = 0; end
        M_ERR: begin
          if (hs && in_data == 8'hA5) begin m_mode = M_FRAME; m_pos = 0; end
          else if (reload) m_mode = M_HUNT;
        end
        default: m_mode = M_HUNT;
      endcase
    end
    m_ready = (m_mode != M_OK);
  end

  task automatic cmp_dut(input string t, input logic [15:0] base, input logic rdy,
                         input logic we, input logic [15:0] addr, input logic [15:0] wd,
                         input logic hold, input logic bsy, input logic ok,
                         input logic err, input logic [15:0] words);
    check({t, ".in_ready"}, 32'(rdy), 32'(m_ready));
    check({t, ".imem_we"}, 32'(we), 32'(m_we));
    check({t, ".imem_addr"}, 32'(addr), 32'(16'(base + 16'(2 * m_idx))));
    check({t, ".imem_wdata"}, 32'(wd), 32'(m_wdata));
    check({t, ".cpu_hold"}, 32'(hold), 32'(m_mode != M_OK));
    check({t, ".busy"}, 32'(bsy), 32'(m_mode == M_FRAME));
    check({t, ".load_ok"}, 32'(ok), 32'(m_mode == M_OK));
    check({t, ".load_err"}, 32'(err), 32'(m_mode == M_ERR));
    check({t, ".words_loaded"}, 32'(words), 32'(m_words));
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      cmp_dut("a", 16'h0000, ready_a, we_a, addr_a, wdata_a, hold_a, busy_a, ok_a, err_a, words_a);
      cmp_dut("b", 16'h0100, ready_b, we_b, addr_b, wdata_b, hold_b, busy_b, ok_b, err_b, words_b);
    end
  end

  logic [15:0] mem_a [logic [15:0]];
  logic [15:0] mem_b [logic [15:0]];
  int          wcnt_a = 0;

  always @(negedge clk) begin
    if (we_a) begin mem_a[addr_a] = wdata_a; wcnt_a++; end
    if (we_b) mem_b[addr_b] = wdata_b;
  end

  function automatic logic [31:0] rd_a(input logic [15:0] k);
    return mem_a.exists(k) ? 32'(mem_a[k]) : 32'hDEAD;
  endfunction
  function automatic logic [31:0] rd_b(input logic [15:0] k);
    return mem_b.exists(k) ? 32'(mem_b[k]) : 32'hDEAD;
  endfunction

  task automatic send(input logic [7:0] b);
    int t;
    logic rdy;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t   = 0;
    rdy = ready_a;
    while (!rdy && t < 20) begin
      @(negedge clk);
      rdy = ready_a;
      t++;
    end
    if (!rdy) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: in_ready stuck 0 for byte %h", b);
    end else @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
    idle(2);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic check_reset_vals(input string t);
    check({t, ".in_ready"}, 32'(ready_a), 32'h1);
    check({t, ".imem_we"}, 32'(we_a), 32'h0);
    check({t, ".imem_addr"}, 32'(addr_a), 32'h0000);
    check({t, ".imem_wdata"}, 32'(wdata_a), 32'h0000);
    check({t, ".cpu_hold"}, 32'(hold_a), 32'h1);
    check({t, ".busy"}, 32'(busy_a), 32'h0);
    check({t, ".load_ok"}, 32'(ok_a), 32'h0);
    check({t, ".load_err"}, 32'(err_a), 32'h0);
    check({t, ".words_loaded"}, 32'(words_a), 32'h0);
    check({t, ".addr_b"}, 32'(addr_b), 32'h0100);
  endtask

  logic [7:0] good[$] = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
  int w0;

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;

    // Good frame
    w0 = wcnt_a;
    send_frame(good);
    check("good.w0", rd_a(16'h0000), 32'h1234);
    check("good.w1", rd_a(16'h0002), 32'h5678);
    check("good.nwr", 32'(wcnt_a - w0), 32'd2);
    check("good.ok", 32'(ok_a), 32'h1);
    check("good.hold", 32'(hold_a), 32'h0);
    check("good.words", 32'(words_a), 32'd2);
    check("good.ready", 32'(ready_a), 32'h0);

    // Reload from DONE
    pulse_reload();
    check("reload.hold", 32'(hold_a), 32'h1);
    check("reload.ok", 32'(ok_a), 32'h0);
    check("reload.words", 32'(words_a), 32'h0);

    // Bad checksum, then recovery straight from ERROR
    mem_a.delete();
    w0 = wcnt_a;
    send_frame('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09});
    check("badchk.nwr", 32'(wcnt_a - w0), 32'd2);
    check("badchk.err", 32'(err_a), 32'h1);
    check("badchk.hold", 32'(hold_a), 32'h1);
    mem_a.delete();
    send_frame('{8'hA5, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h66});
    check("recover.w0", rd_a(16'h0000), 32'hABCD);
    check("recover.ok", 32'(ok_a), 32'h1);
    check("recover.err", 32'(err_a), 32'h0);
    check("recover.words", 32'(words_a), 32'd1);
    pulse_reload();

    // Length errors: zero and MAX_WORDS+1
    w0 = wcnt_a;
    send_frame('{8'hA5, 8'h00, 8'h00});
    check("len0.err", 32'(err_a), 32'h1);
    send_frame('{8'hA5, 8'h01, 8'h01});
    check("len257.err", 32'(err_a), 32'h1);
    check("lenerr.nwr", 32'(wcnt_a - w0), 32'd0);
    pulse_reload();
    check("errreload.err", 32'(err_a), 32'h0);
    check("errreload.hold", 32'(hold_a), 32'h1);

    // Garbage then a frame with a 5-cycle input stall
    mem_a.delete();
    foreach (good[i]) begin
      if (i == 0) begin send(8'h00); send(8'hFF); send(8'h3C); end
      if (i == 4) idle(5);
      send(good[i]);
    end
    idle(2);
    check("stall.w0", rd_a(16'h0000), 32'h1234);
    check("stall.w1", rd_a(16'h0002), 32'h5678);
    check("stall.ok", 32'(ok_a), 32'h1);
    pulse_reload();

    // Reset mid-frame, then a normal frame
    send(8'hA5); send(8'h00); send(8'h02); send(8'h12);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b1;
    mem_a.delete();
    send_frame(good);
    check("postrst.w1", rd_a(16'h0002), 32'h5678);
    check("postrst.ok", 32'(ok_a), 32'h1);
    pulse_reload();

    // Second instance at BASE_ADDR 0100
    mem_b.delete();
    send_frame(good);
    check("base.w0", rd_b(16'h0100), 32'h1234);
    check("base.w1", rd_b(16'h0102), 32'h5678);
    check("base.ok", 32'(ok_b), 32'h1);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream of the single-cycle 16-bit core.
- Receives a framed program image as a byte stream over a valid/ready handshake.
- Packs bytes into 16-bit words and writes them into instruction memory at byte addresses BASE_ADDR, +2, +4, … (PC increments by 2).
- Holds the processor in reset until a complete image with a valid checksum has been written.

Parameters:
- MAGIC, 8'hA5, frame start byte.
- BASE_ADDR, 16'h0000, byte address of the first instruction word.
- MAX_WORDS, 256, largest accepted word count (1..65535).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- in_valid  in  1  byte-stream data valid.
- in_data  in  8  byte-stream payload.
- in_ready  out  1  loader can accept a byte; transfer occurs when in_valid && in_ready.
- reload  in  1  single-cycle request to start a new load (honoured only in DONE or ERROR).
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  16  byte address of the word being written.
- imem_wdata  out  16  instruction word, {hi byte, lo byte}.
- cpu_hold  out  1  active-high; drives the processor's reset input.
- busy  out  1  frame in progress (states LEN_HI through CHECK).
- load_ok  out  1  level; image accepted.
- load_err  out  1  level; framing or checksum failure.
- words_loaded  out  16  count of words written in the current or last frame.

Behaviour:
- Reset values (reset==0 at a clock edge):
  - state=IDLE.
  - in_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - cpu_hold=1, busy=0, load_ok=0, load_err=0, words_loaded=0.
  - Internal checksum=0, word counter=0.
- Reset mid-frame discards all progress. Words already written stay in memory but are not considered valid.
- in_ready=1 in IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK and ERROR; in_ready=0 in DONE. Bytes are only consumed on handshake. in_valid low stalls the FSM indefinitely; there is no timeout.
- FSM (transitions occur on handshake unless noted):
  - IDLE: byte==MAGIC → LEN_HI; any other byte is discarded, stay in IDLE.
  - LEN_HI: latch len[15:8] → LEN_LO.
  - LEN_LO: latch len[7:0]. If the 16-bit len==0 or len>MAX_WORDS → ERROR. Otherwise clear checksum and word counter → DATA_HI.
  - DATA_HI: latch hi byte, checksum^=byte → DATA_LO.
  - DATA_LO: checksum^=byte. On the next cycle imem_we=1 for exactly one cycle, with imem_addr=BASE_ADDR+2*count and imem_wdata={hi,lo}; count and words_loaded increment. If count+1==len → CHECK, else → DATA_HI.
  - CHECK: byte==checksum → DONE, else → ERROR.
  - DONE: cpu_hold=0, load_ok=1. reload=1 → IDLE, with cpu_hold=1, load_ok=0, words_loaded=0.
  - ERROR: cpu_hold=1, load_err=1. A byte==MAGIC arriving on handshake → LEN_HI and clears load_err. reload=1 → IDLE and clears load_err. If both happen in the same cycle, MAGIC wins (→ LEN_HI).
- Write latency: the imem_we pulse follows the DATA_LO handshake by 1 cycle. Back-to-back bytes, one per cycle, are sustained; the write pipeline register never stalls input.
- cpu_hold deasserts in the same cycle load_ok rises, which is at least 1 cycle after the last imem_we. This guarantees the final write has landed before the core leaves reset.
- Address arithmetic is 16-bit modulo. Wrap past 16'hFFFE is permitted and not flagged.
- Checksum is the XOR of data bytes only; magic and length bytes are excluded.
- reload in IDLE or mid-frame is ignored.
- busy=1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.

Decomposition:
- Shared package boot_loader_pkg contains:
  - state encoding constants: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR (3-bit);
  - default MAGIC;
  - instruction word width, 16.
- Single module; no sub-module. The write pipeline register and checksum accumulator are too small to split out.

Test Plan:
- Good frame: A5 00 02 12 34 56 78 chk=12^34^56^78=08.
  - imem_we pulses at addr 0000 with 1234, then addr 0002 with 5678.
  - load_ok=1, cpu_hold=0, words_loaded=2.
- Bad checksum: same frame with chk=09.
  - Both writes occur; load_err=1, cpu_hold stays 1.
  - A following A5 00 01 AB CD 66 reaches DONE with word ABCD at 0000.
- Length errors: A5 00 00 → ERROR. A5 01 01, i.e. 257 with MAX_WORDS=256 → ERROR. No imem_we in either case.
- Garbage then stall: 00 FF 3C before A5 are ignored. Dropping in_valid for 5 cycles between 12 and 34 gives the same memory contents as the good frame.
- Reset mid-frame: reset=0 after byte 12 → all outputs at reset values. A full good frame afterwards succeeds normally.
- Reload: in DONE pulse reload → IDLE, cpu_hold=1 next cycle. A new frame with BASE_ADDR=16'h0100 writes at 0100/0102.
